// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
// Shared types and constants for the multiplexed seven-segment driver.
//   digit_t    : one hex nibble per display digit
//   SEG_OFF    : 8-bit all-segments-off pattern (active-low encoding)
//   hex_to_seg : 16-entry hex font, returns gfedcba in active-low form
// -----------------------------------------------------------------------------
package seven_seg_pkg;

    typedef logic [3:0] digit_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    function automatic logic [6:0] hex_to_seg(input digit_t nib);
        logic [6:0] pat;
        pat = 7'b1111111;
        case (nib)
            4'h0: pat = 7'b1000000;
            4'h1: pat = 7'b1111001;
            4'h2: pat = 7'b0100100;
            4'h3: pat = 7'b0110000;
            4'h4: pat = 7'b0011001;
            4'h5: pat = 7'b0010010;
            4'h6: pat = 7'b0000010;
            4'h7: pat = 7'b1111000;
            4'h8: pat = 7'b0000000;
            4'h9: pat = 7'b0010000;
            4'hA: pat = 7'b0001000;
            4'hB: pat = 7'b0000011;
            4'hC: pat = 7'b1000110;
            4'hD: pat = 7'b0100001;
            4'hE: pat = 7'b0000110;
            4'hF: pat = 7'b0001110;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seven_seg_timebase.sv
// -----------------------------------------------------------------------------
// seven_seg_timebase
// Digit-scan timebase: a slot counter of REFRESH_DIV clocks per digit and a
// digit index that advances on every slot wrap.
// Ports:
//   clk, reset   : system clock, asynchronous active-high reset
//   slot_cnt     : position within the current digit slot, 0..REFRESH_DIV-1
//   digit_idx    : digit currently being scanned, 0..NUM_DIGITS-1
//   frame_bnd    : last cycle of the last digit's slot (frame boundary)
//   frame_first  : first cycle of digit 0's slot (unregistered)
// -----------------------------------------------------------------------------
module seven_seg_timebase
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int NUM_DIGITS  = 4,
    localparam int SLOT_W     = $clog2(REFRESH_DIV),
    localparam int IDX_W      = $clog2(NUM_DIGITS)
) (
    input  logic              clk,
    input  logic              reset,
    output logic [SLOT_W-1:0] slot_cnt,
    output logic [IDX_W-1:0]  digit_idx,
    output logic              frame_bnd,
    output logic              frame_first
);

    logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0]  digit_idx_q, digit_idx_d;
    logic              slot_last;
    logic              digit_last;

    always_comb begin
        slot_last   = (slot_cnt_q == SLOT_W'(REFRESH_DIV - 1));
        digit_last  = (digit_idx_q == IDX_W'(NUM_DIGITS - 1));
        slot_cnt_d  = slot_cnt_q + SLOT_W'(1);
        digit_idx_d = digit_idx_q;
        if (slot_last) begin
            slot_cnt_d  = '0;
            digit_idx_d = digit_last ? '0 : digit_idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt_q  <= '0;
            digit_idx_q <= '0;
        end else begin
            slot_cnt_q  <= slot_cnt_d;
            digit_idx_q <= digit_idx_d;
        end
    end

    assign slot_cnt    = slot_cnt_q;
    assign digit_idx   = digit_idx_q;
    assign frame_bnd   = slot_last && digit_last;
    assign frame_first = (slot_cnt_q == '0) && (digit_idx_q == '0);

endmodule

// File: rtl/seven_seg_mux.sv
// -----------------------------------------------------------------------------
// seven_seg_mux
// Multiplexed seven-segment display driver with double-buffered writes,
// 16-level PWM brightness, an anti-ghosting guard interval and optional
// leading-zero suppression.
// Ports:
//   clk, reset   : system clock, asynchronous active-high reset
//   wr_valid     : write offered           wr_ready : pending buffer empty
//   wr_digits    : nibble per digit (digit 0 = bits [3:0], rightmost)
//   wr_dp        : decimal point per digit wr_blank : force digit dark
//   brightness   : live duty level 0..15   lz_suppress : live LZ enable
//   seg          : {dp, gfedcba}           an : anode per digit
//   frame_start  : pulse on the first cycle of digit 0's slot
// -----------------------------------------------------------------------------
module seven_seg_mux
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 64,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [4*NUM_DIGITS-1:0] wr_digits,
    input  logic [NUM_DIGITS-1:0]   wr_dp,
    input  logic [NUM_DIGITS-1:0]   wr_blank,
    input  logic [3:0]              brightness,
    input  logic                    lz_suppress,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int SLOT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int STEP   = REFRESH_DIV / 16;

    // Idle pin levels in the board's polarity.
    localparam logic [7:0]            SEG_IDLE = ACTIVE_LOW ? SEG_OFF : ~SEG_OFF;
    localparam logic [NUM_DIGITS-1:0] AN_IDLE  = ACTIVE_LOW ? '1 : '0;

    // ---------------- timebase ----------------
    logic [SLOT_W-1:0] slot_cnt;
    logic [IDX_W-1:0]  digit_idx;
    logic              frame_bnd;
    logic              frame_first;

    seven_seg_timebase #(
        .REFRESH_DIV (REFRESH_DIV),
        .NUM_DIGITS  (NUM_DIGITS)
    ) u_timebase (
        .clk         (clk),
        .reset       (reset),
        .slot_cnt    (slot_cnt),
        .digit_idx   (digit_idx),
        .frame_bnd   (frame_bnd),
        .frame_first (frame_first)
    );

    // ---------------- write handshake and double buffer ----------------
    logic                    pend_vld_q, pend_vld_d;
    logic [4*NUM_DIGITS-1:0] pend_digits_q, pend_digits_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
    logic [4*NUM_DIGITS-1:0] disp_digits_q, disp_digits_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [NUM_DIGITS-1:0]   disp_blank_q, disp_blank_d;
    logic                    accept;
    logic                    commit;

    // Accept needs an empty pending buffer and commit needs a full one, so the
    // two never fire together; a write landing on the boundary cycle waits a
    // whole frame because the boundary still sees the buffer empty.
    always_comb begin
        accept        = wr_valid && !pend_vld_q;
        commit        = frame_bnd && pend_vld_q;
        pend_vld_d    = pend_vld_q;
        pend_digits_d = pend_digits_q;
        pend_dp_d     = pend_dp_q;
        pend_blank_d  = pend_blank_q;
        disp_digits_d = disp_digits_q;
        disp_dp_d     = disp_dp_q;
        disp_blank_d  = disp_blank_q;
        if (commit) begin
            disp_digits_d = pend_digits_q;
            disp_dp_d     = pend_dp_q;
            disp_blank_d  = pend_blank_q;
            pend_vld_d    = 1'b0;
        end
        if (accept) begin
            pend_digits_d = wr_digits;
            pend_dp_d     = wr_dp;
            pend_blank_d  = wr_blank;
            pend_vld_d    = 1'b1;
        end
    end

    assign wr_ready = !pend_vld_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_vld_q    <= 1'b0;
            disp_digits_q <= '0;
            disp_dp_q     <= '0;
            disp_blank_q  <= '1;
        end else begin
            pend_vld_q    <= pend_vld_d;
            disp_digits_q <= disp_digits_d;
            disp_dp_q     <= disp_dp_d;
            disp_blank_q  <= disp_blank_d;
        end
    end

    // Pending payload is only meaningful while pend_vld_q is set.
    always_ff @(posedge clk) begin
        pend_digits_q <= pend_digits_d;
        pend_dp_q     <= pend_dp_d;
        pend_blank_q  <= pend_blank_d;
    end

    // ---------------- leading-zero suppression ----------------
    logic [NUM_DIGITS-1:0] lz_dark;
    logic                  zero_run;

    // Walk from the leftmost digit down; the run of "0 with no dp" digits is
    // suppressed, except digit 0 which always shows.
    always_comb begin
        lz_dark  = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run   = zero_run && (disp_digits_q[4*i +: 4] == 4'h0) && !disp_dp_q[i];
            lz_dark[i] = lz_suppress && zero_run && (i != 0);
        end
    end

    // ---------------- current digit, PWM compare, pin encode ----------------
    digit_t                cur_nib;
    logic                  cur_dp;
    logic                  cur_dark;
    logic [31:0]           slot_ext;
    logic [31:0]           pwm_lim;
    logic                  lit;
    logic [7:0]            seg_raw;
    logic [NUM_DIGITS-1:0] an_on;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_start_q, frame_start_d;

    // A dark digit also keeps its anode off, so a blank display draws no
    // current and shows nothing even through the segment drivers' leakage.
    always_comb begin
        cur_nib  = disp_digits_q[4*digit_idx +: 4];
        cur_dp   = disp_dp_q[digit_idx];
        cur_dark = disp_blank_q[digit_idx] || lz_dark[digit_idx];
        slot_ext = 32'(slot_cnt);
        pwm_lim  = (32'(brightness) + 32'd1) * 32'(STEP);
        lit      = (slot_ext >= 32'(GUARD)) && (slot_ext < pwm_lim) && !cur_dark;

        seg_raw = SEG_OFF;
        if (!cur_dark) begin
            seg_raw = {!cur_dp, hex_to_seg(cur_nib)};
        end

        an_on = '0;
        if (lit) begin
            an_on[digit_idx] = 1'b1;
        end

        seg_d         = ACTIVE_LOW ? seg_raw : ~seg_raw;
        an_d          = ACTIVE_LOW ? ~an_on : an_on;
        frame_start_d = frame_first;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q         <= SEG_IDLE;
            an_q          <= AN_IDLE;
            frame_start_q <= 1'b0;
        end else begin
            seg_q         <= seg_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule
